// File: rtl/t_down_counter_timer.sv
// Loadable down-counter/timer with toggle-rule decrement.
// One-shot or auto-reload countdown with a registered done pulse.
module t_down_counter_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] tmask;
  logic [WIDTH-1:0] dec;
  logic             at_one;

  // Toggle mask: bit i flips when every lower bit is already zero
  always_comb begin
    tmask[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      tmask[i] = tmask[i-1] & ~count[i-1];
    end
    dec    = count ^ tmask;
    at_one = (count == WIDTH'(1));
  end

  // Control FSM with registered count, busy and done
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      reload_q <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        count    <= load_value;
        reload_q <= load_value;
        state    <= IDLE;
        busy     <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              if (count != '0) begin
                state <= RUN;
                busy  <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end
          end
          RUN: begin
            if (enable) begin
              if (!at_one && count != '0) begin
                count <= dec;
              end else begin
                // Terminal count; a zero count here is treated
                // the same way so the counter can never wrap.
                done <= 1'b1;
                if (auto_reload && reload_q != '0) begin
                  count <= reload_q;
                end else begin
                  count <= '0;
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_t_down_counter_timer.sv
// Directed bench for t_down_counter_timer (WIDTH=3).
// Hand-computed expectations checked through one task.
module tb_t_down_counter_timer;

  logic       clock = 1'b0;
  logic       reset;
  logic       load;
  logic [2:0] load_value;
  logic       start;
  logic       enable;
  logic       auto_reload;
  logic [2:0] count;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  t_down_counter_timer #(.WIDTH(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .enable     (enable),
    .auto_reload(auto_reload),
    .count      (count),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk3(input string tag,
                      input int c, input int b, input int d);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".done"},  32'(done),  32'(d));
  endtask

  task automatic do_load(input logic [2:0] v);
    load = 1'b1;
    load_value = v;
    step();
    load = 1'b0;
  endtask

  int en_pat [9] = '{1, 1, 0, 0, 1, 1, 1, 1, 1};
  int cn_pat [9] = '{6, 5, 5, 5, 4, 3, 2, 1, 0};
  int ar_cnt [6] = '{2, 1, 3, 2, 1, 3};

  initial begin
    reset = 1'b0;
    load = 1'b1;
    load_value = 3'd5;
    start = 1'b1;
    enable = 1'b1;
    auto_reload = 1'b0;
    step();
    step();
    chk3("rst", 0, 0, 0);

    // Start at zero count: single done pulse, stays idle
    reset = 1'b1;
    load = 1'b0;
    start = 1'b1;
    step();
    chk3("zstart", 0, 0, 1);
    start = 1'b0;
    step();
    chk3("zstart_after", 0, 0, 0);

    // One-shot from 5
    do_load(3'd5);
    chk3("os_load", 5, 0, 0);
    start = 1'b1;
    enable = 1'b1;
    step();
    start = 1'b0;
    chk3("os_e0", 5, 1, 0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk3($sformatf("os_e%0d", i), 5 - i,
           (i != 5) ? 1 : 0, (i == 5) ? 1 : 0);
    end

    // Full scale with pause
    do_load(3'd7);
    start = 1'b1;
    step();
    start = 1'b0;
    chk3("fs_e0", 7, 1, 0);
    for (int i = 0; i < 9; i++) begin
      enable = en_pat[i][0];
      step();
      chk3($sformatf("fs_%0d", i), cn_pat[i],
           (i != 8) ? 1 : 0, (i == 8) ? 1 : 0);
    end
    enable = 1'b1;

    // Auto-reload period 3
    auto_reload = 1'b1;
    do_load(3'd3);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk3($sformatf("ar_%0d", i), ar_cnt[i], 1,
           (ar_cnt[i] == 3) ? 1 : 0);
    end
    auto_reload = 1'b0;
    step();
    chk3("ar_off0", 2, 1, 0);
    step();
    chk3("ar_off1", 1, 1, 0);
    step();
    chk3("ar_off2", 0, 0, 1);

    // Load during run beats start
    do_load(3'd6);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk3("lr_run", 4, 1, 0);
    load = 1'b1;
    load_value = 3'd2;
    start = 1'b1;
    step();
    load = 1'b0;
    start = 1'b0;
    chk3("lr_load", 2, 0, 0);
    step();
    chk3("lr_hold", 2, 0, 0);

    // Reset mid-run abandons with no done
    do_load(3'd5);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk3("rm_run", 3, 1, 0);
    reset = 1'b0;
    step();
    chk3("rm_rst", 0, 0, 0);
    reset = 1'b1;
    step();
    chk3("rm_after", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/t_down_counter_timer.md
Name: t_down_counter_timer

Overview:
- Loadable, parameterised down-counter/timer built from toggle-style bit updates. It is the count-down counterpart to the 3-bit T-flip-flop up-counter.
- Loads a start value and decrements once per enabled cycle while running. It pulses `done` on reaching terminal count and can optionally auto-reload for periodic ticks.
- Used as the countdown/delay element for control FSMs in the same lab designs.

Parameters:
- WIDTH, 3, counter width in bits; legal range 2..16.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset; sampled on posedge clock.
- load  input  1  capture `load_value` into `count` and into the reload register.
- load_value  input  WIDTH  value captured on `load`.
- start  input  1  begin counting; honoured only in IDLE.
- enable  input  1  count enable in RUN; 0 = pause, state held.
- auto_reload  input  1  1 = reload on terminal count and keep running; 0 = stop at 0.
- count  output  WIDTH  current counter value.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse on terminal count.

Behaviour:
- Reset (reset==0 at posedge), checked before every other condition:
  - count=0, reload register=0, state=IDLE, busy=0, done=0.
  - Applies mid-operation; the run is abandoned with no `done` pulse.
- All outputs are registered. `done` defaults to 0 every cycle unless set below.
- FSM states: IDLE, RUN. `busy` = (state==RUN), registered.
- Priority per edge: reset > load > start/terminal/decrement.
- load==1, any state:
  - count<=load_value, reload<=load_value, state<=IDLE, done<=0.
  - `start` on the same edge is ignored.
- IDLE, start==1:
  - count!=0: state<=RUN; count unchanged on that edge.
  - count==0: done<=1 for one cycle; stay IDLE.
- IDLE, start==0: hold everything.
- RUN, enable==0: hold count and state; done=0.
- RUN, enable==1, count>1: decrement using the T rule.
  - Bit 0 always toggles.
  - Bit i toggles iff count[i-1:0]==0.
- RUN, enable==1, count==1 (terminal), done<=1 in all cases:
  - auto_reload==0: count<=0, state<=IDLE.
  - auto_reload==1 and reload!=0: count<=reload, stay RUN.
  - auto_reload==1 and reload==0: count<=0, state<=IDLE.
- Timing:
  - Non-reload run length = N enabled cycles after the start edge, for loaded N.
  - Auto-reload `done` period = reload value, in enabled cycles.
- `start` while in RUN is ignored. Count never wraps below 0.
- `auto_reload` is sampled only at the terminal-count edge; it may change freely otherwise.

Test Plan:
- Reset: hold reset=0 for 2 edges, with load=1 and start=1 asserted -> count=0, busy=0, done=0. Reset wins over load.
- One-shot, WIDTH=3: load 5; start at edge E0; enable=1 -> busy=1 after E0; count 4,3,2,1,0 after E1..E5; done=1 only after E5; busy=0 after E5.
- Full scale with pause: load 7, start, enable toggled 1,1,0,0,1... -> count 6,5,5,5,4,...,0; held during pause; single `done` pulse; 4->3 and 2->1 multi-bit toggles correct.
- Auto-reload: load 3, auto_reload=1, start, enable=1 -> count 2,1,3,2,1,3; done pulses every 3rd cycle; busy stays 1. Then drop auto_reload -> stops at 0 after next terminal; busy=0.
- Load in RUN: load 6, start, run to 4, assert load with value 2 and start=1 on the same edge -> count=2, state IDLE, busy=0, no `done` pulse.
- Start at zero, and reset mid-run:
  - After reset, start=1 -> done pulse one cycle; busy stays 0; count 0.
  - Load 5, start, reset=0 at count=3 -> count=0, busy=0, no `done` pulse.
